clock_controller: RTL and testbench
===================================

CLOCK_CONTROLLER -- requirements
Module: clock_controller

Interface
REQ-001 Parameter CNT_W, default 16, width of the run-count load value and down-counter.
REQ-002 Parameter CYC_W, default 32, width of the enabled-cycle counter.
REQ-003 CLOCK  input  1  single system clock; all state updates on rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 START  input  1  request continuous or counted run; sampled each cycle.
REQ-006 STEP  input  1  request exactly one enabled cycle.
REQ-007 HALT_REQ  input  1  external stop request.
REQ-008 CPU_HALT  input  1  stop request from the CPU, e.g. a halt instruction.
REQ-009 CLEAR  input  1  return to IDLE and zero CYCLES.
REQ-010 COUNT_MODE  input  1  1 = counted run of RUN_COUNT cycles; 0 = free run.
REQ-011 RUN_COUNT  input  CNT_W  enabled-cycle budget, latched on run entry.
REQ-012 ENABLE  output  1  registered enable driving the clock block's ENABLE input.
REQ-013 STATE  output  2  IDLE=00, RUN=01, STEP=10, HALTED=11.
REQ-014 DONE  output  1  one-cycle pulse on every entry to HALTED.
REQ-015 HALT_CAUSE  output  2  00 none, 01 count expired, 10 HALT_REQ, 11 CPU_HALT.
REQ-016 CYCLES  output  CYC_W  number of cycles with ENABLE=1 since reset or CLEAR.

Function
REQ-017 ENABLE SHALL be 1 exactly in cycles where STATE is RUN or STEP, from a flop, glitch-free.
REQ-018 IDLE/HALTED: STEP SHALL go to STEP; else START SHALL go to RUN; HALT_REQ or CPU_HALT high SHALL block both (state held).
REQ-019 Run entry with COUNT_MODE=1 SHALL latch RUN_COUNT into the down-counter; ENABLE high exactly RUN_COUNT cycles, then HALTED, HALT_CAUSE=01.
REQ-020 Run entry with COUNT_MODE=1 and RUN_COUNT=0 SHALL go directly to HALTED, no ENABLE cycle, DONE pulsed, HALT_CAUSE=01.
REQ-021 COUNT_MODE=0 run SHALL continue until HALT_REQ or CPU_HALT; COUNT_MODE and RUN_COUNT ignored after entry.
REQ-022 In RUN, HALT_REQ or CPU_HALT sampled in cycle t SHALL make cycle t the last ENABLE=1 cycle; STATE=HALTED in t+1.
REQ-023 Halt cause priority: CPU_HALT (11) > HALT_REQ (10) > count expiry (01) when coincident.
REQ-024 STEP state SHALL last exactly one cycle, then HALTED with HALT_CAUSE=00 unless CPU_HALT/HALT_REQ high that cycle.
REQ-025 START and STEP SHALL be ignored in RUN and STEP states.
REQ-026 DONE SHALL pulse for exactly one cycle, the first cycle STATE=HALTED; not re-pulsed while held.
REQ-027 HALT_CAUSE SHALL update on HALTED entry, hold until next HALTED entry or CLEAR/reset.
REQ-028 CYCLES SHALL increment by 1 each cycle ENABLE=1 and saturate at all-ones (no wrap).
REQ-029 CLEAR SHALL have top priority over all inputs in every state: next cycle STATE=IDLE, ENABLE=0, CYCLES=0, HALT_CAUSE=00, DONE=0.
REQ-030 Down-counter SHALL decrement only while ENABLE=1 in RUN; expiry when it reaches 0 after a decrement.

Reset
REQ-031 RESET_N low SHALL immediately, independent of CLOCK, force STATE=IDLE, ENABLE=0, DONE=0, HALT_CAUSE=00, CYCLES=0, down-counter=0.
REQ-032 Reset asserted mid-RUN SHALL drop ENABLE asynchronously; no DONE pulse generated.
REQ-033 After RESET_N deasserts, the block SHALL remain in IDLE until START or STEP.

Verification
REQ-034 Counted run: COUNT_MODE=1, RUN_COUNT=5, START pulse -> ENABLE high exactly 5 cycles, DONE pulse, HALT_CAUSE=01, CYCLES=5.
REQ-035 Free run interrupted: COUNT_MODE=0, START, HALT_REQ on 10th enabled cycle -> 10 ENABLE cycles, HALTED, HALT_CAUSE=10; then STEP -> CYCLES=11, HALT_CAUSE=00.
REQ-036 Coincidence: RUN_COUNT=3 run with CPU_HALT and HALT_REQ both high in 3rd enabled cycle -> 3 ENABLE cycles, HALT_CAUSE=11, single DONE.
REQ-037 Zero budget and priority: COUNT_MODE=1, RUN_COUNT=0, START -> HALTED next cycle, ENABLE never high; START+STEP together in HALTED -> STEP taken, one ENABLE cycle.
REQ-038 Reset/clear: RESET_N low mid-RUN -> ENABLE=0 immediately, all outputs at reset values; CLEAR in HALTED with CYCLES=7 -> IDLE, CYCLES=0.
REQ-039 Saturation: CYC_W=4, free run 20 cycles -> CYCLES holds 15.

Source files
------------

// File: rtl/clock_controller.sv
// Run/step/halt controller that gates a downstream clock block via ENABLE.
// Supports free runs, counted runs, single steps and enabled-cycle counting.
module clock_controller #(
    parameter int CNT_W = 16,
    parameter int CYC_W = 32
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic             STEP,
    input  logic             HALT_REQ,
    input  logic             CPU_HALT,
    input  logic             CLEAR,
    input  logic             COUNT_MODE,
    input  logic [CNT_W-1:0] RUN_COUNT,
    output logic             ENABLE,
    output logic [1:0]       STATE,
    output logic             DONE,
    output logic [1:0]       HALT_CAUSE,
    output logic [CYC_W-1:0] CYCLES
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_STEP   = 2'b10,
        S_HALTED = 2'b11
    } state_t;

    localparam logic [1:0] C_NONE   = 2'b00;
    localparam logic [1:0] C_EXPIRE = 2'b01;
    localparam logic [1:0] C_HREQ   = 2'b10;
    localparam logic [1:0] C_CPU    = 2'b11;

    state_t           state_q, state_d;
    logic             enable_q;
    logic             done_q;
    logic [1:0]       cause_q, cause_d;
    logic [CYC_W-1:0] cycles_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             counted_q, counted_d;
    logic             halt_entry;
    logic             ext_stop;
    logic [1:0]       ext_cause;

    // External stop requests, CPU halt taking precedence over HALT_REQ.
    always_comb begin
        ext_stop  = HALT_REQ | CPU_HALT;
        ext_cause = CPU_HALT ? C_CPU : (HALT_REQ ? C_HREQ : C_NONE);
    end

    // Next-state, budget counter and halt-cause selection.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        counted_d  = counted_q;
        cause_d    = cause_q;
        halt_entry = 1'b0;
        if (CLEAR) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            counted_d = 1'b0;
            cause_d   = C_NONE;
        end else begin
            case (state_q)
                S_IDLE, S_HALTED: begin
                    if (!ext_stop) begin
                        if (STEP) begin
                            state_d = S_STEP;
                        end else if (START) begin
                            if (COUNT_MODE && RUN_COUNT == '0) begin
                                state_d    = S_HALTED;
                                cause_d    = C_EXPIRE;
                                halt_entry = 1'b1;
                                counted_d  = 1'b0;
                                cnt_d      = '0;
                            end else begin
                                state_d   = S_RUN;
                                counted_d = COUNT_MODE;
                                cnt_d     = COUNT_MODE ? RUN_COUNT : '0;
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (counted_q) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                    if (ext_stop) begin
                        state_d    = S_HALTED;
                        cause_d    = ext_cause;
                        halt_entry = 1'b1;
                    end else if (counted_q && cnt_q == CNT_W'(1)) begin
                        state_d    = S_HALTED;
                        cause_d    = C_EXPIRE;
                        halt_entry = 1'b1;
                    end
                end
                S_STEP: begin
                    state_d    = S_HALTED;
                    cause_d    = ext_cause;
                    halt_entry = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, enable and done flops; ENABLE mirrors the registered state.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            enable_q  <= 1'b0;
            done_q    <= 1'b0;
            cause_q   <= C_NONE;
            cnt_q     <= '0;
            counted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            enable_q  <= (state_d == S_RUN) || (state_d == S_STEP);
            done_q    <= halt_entry;
            cause_q   <= cause_d;
            cnt_q     <= cnt_d;
            counted_q <= counted_d;
        end
    end

    // Saturating count of enabled cycles.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            cycles_q <= '0;
        end else if (CLEAR) begin
            cycles_q <= '0;
        end else if (enable_q && cycles_q != '1) begin
            cycles_q <= cycles_q + CYC_W'(1);
        end
    end

    assign ENABLE     = enable_q;
    assign STATE      = state_q;
    assign DONE       = done_q;
    assign HALT_CAUSE = cause_q;
    assign CYCLES     = cycles_q;

endmodule

// File: tb/tb_clock_controller.sv
// Directed bench for clock_controller: counted/free runs, steps,
// halt priority, zero budget, reset, clear and cycle saturation.
module tb_clock_controller;

    logic        CLOCK = 1'b0;
    logic        RESET_N;
    logic        START, STEP, HALT_REQ, CPU_HALT, CLEAR, COUNT_MODE;
    logic [15:0] RUN_COUNT;
    logic        ENABLE, DONE;
    logic [1:0]  STATE, HALT_CAUSE;
    logic [31:0] CYCLES;
    logic        enable_s, done_s;
    logic [1:0]  state_s, cause_s;
    logic [3:0]  cycles_s;

    int checks = 0;
    int errors = 0;
    int en_cnt;
    int guard;

    clock_controller dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START), .STEP(STEP),
        .HALT_REQ(HALT_REQ), .CPU_HALT(CPU_HALT), .CLEAR(CLEAR),
        .COUNT_MODE(COUNT_MODE), .RUN_COUNT(RUN_COUNT), .ENABLE(ENABLE),
        .STATE(STATE), .DONE(DONE), .HALT_CAUSE(HALT_CAUSE), .CYCLES(CYCLES)
    );

    clock_controller #(.CNT_W(16), .CYC_W(4)) dut_sat (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START), .STEP(STEP),
        .HALT_REQ(HALT_REQ), .CPU_HALT(CPU_HALT), .CLEAR(CLEAR),
        .COUNT_MODE(COUNT_MODE), .RUN_COUNT(RUN_COUNT), .ENABLE(enable_s),
        .STATE(state_s), .DONE(done_s), .HALT_CAUSE(cause_s), .CYCLES(cycles_s)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_clear();
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0; START = 1'b0; STEP = 1'b0; HALT_REQ = 1'b0;
        CPU_HALT = 1'b0; CLEAR = 1'b0; COUNT_MODE = 1'b0; RUN_COUNT = '0;
        #12;
        check("rst_state", 32'(STATE), 32'd0);
        check("rst_enable", 32'(ENABLE), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_cause", 32'(HALT_CAUSE), 32'd0);
        check("rst_cycles", CYCLES, 32'd0);
        RESET_N = 1'b1;
        tick(); tick(); tick();
        check("post_rst_idle", 32'(STATE), 32'd0);

        // Counted run of 5
        COUNT_MODE = 1'b1; RUN_COUNT = 16'd5; START = 1'b1;
        tick();
        START = 1'b0;
        check("cnt_run_state", 32'(STATE), 32'd1);
        en_cnt = 0; guard = 0;
        while (STATE != 2'b11 && guard < 50) begin
            if (ENABLE) en_cnt++;
            tick();
            guard++;
        end
        check("cnt_halted", 32'(STATE), 32'd3);
        check("cnt_en_cycles", 32'(en_cnt), 32'd5);
        check("cnt_done", 32'(DONE), 32'd1);
        check("cnt_cause", 32'(HALT_CAUSE), 32'd1);
        check("cnt_cycles", CYCLES, 32'd5);
        tick();
        check("cnt_done_once", 32'(DONE), 32'd0);
        check("cnt_hold", 32'(STATE), 32'd3);

        // Free run, HALT_REQ in 10th enabled cycle, then a step
        do_clear();
        check("clr_state", 32'(STATE), 32'd0);
        check("clr_cycles", CYCLES, 32'd0);
        check("clr_cause", 32'(HALT_CAUSE), 32'd0);
        COUNT_MODE = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("free_en10", 32'(ENABLE), 32'd1);
        HALT_REQ = 1'b1;
        tick();
        HALT_REQ = 1'b0;
        check("free_halted", 32'(STATE), 32'd3);
        check("free_en_off", 32'(ENABLE), 32'd0);
        check("free_cause", 32'(HALT_CAUSE), 32'd2);
        check("free_cycles", CYCLES, 32'd10);
        check("free_done", 32'(DONE), 32'd1);
        STEP = 1'b1;
        tick();
        STEP = 1'b0;
        check("step_state", 32'(STATE), 32'd2);
        check("step_en", 32'(ENABLE), 32'd1);
        tick();
        check("step_halted", 32'(STATE), 32'd3);
        check("step_cause", 32'(HALT_CAUSE), 32'd0);
        check("step_cycles", CYCLES, 32'd11);
        check("step_done", 32'(DONE), 32'd1);

        // Coincident CPU_HALT + HALT_REQ on last counted cycle
        do_clear();
        COUNT_MODE = 1'b1; RUN_COUNT = 16'd3; START = 1'b1;
        tick();
        START = 1'b0;
        tick(); tick();
        check("coin_en3", 32'(ENABLE), 32'd1);
        CPU_HALT = 1'b1; HALT_REQ = 1'b1;
        tick();
        check("coin_halted", 32'(STATE), 32'd3);
        check("coin_cause", 32'(HALT_CAUSE), 32'd3);
        check("coin_cycles", CYCLES, 32'd3);
        check("coin_done", 32'(DONE), 32'd1);
        CPU_HALT = 1'b0;
        START = 1'b1;
        tick();
        check("blocked_state", 32'(STATE), 32'd3);
        check("blocked_en", 32'(ENABLE), 32'd0);
        check("coin_single_done", 32'(DONE), 32'd0);
        START = 1'b0; HALT_REQ = 1'b0;

        // Zero budget, then START+STEP together
        do_clear();
        COUNT_MODE = 1'b1; RUN_COUNT = 16'd0; START = 1'b1;
        tick();
        START = 1'b0;
        check("zero_state", 32'(STATE), 32'd3);
        check("zero_en", 32'(ENABLE), 32'd0);
        check("zero_done", 32'(DONE), 32'd1);
        check("zero_cause", 32'(HALT_CAUSE), 32'd1);
        check("zero_cycles", CYCLES, 32'd0);
        START = 1'b1; STEP = 1'b1; RUN_COUNT = 16'd4;
        tick();
        START = 1'b0; STEP = 1'b0;
        check("prio_step", 32'(STATE), 32'd2);
        check("prio_en", 32'(ENABLE), 32'd1);
        tick();
        check("prio_halted", 32'(STATE), 32'd3);
        check("prio_cycles", CYCLES, 32'd1);

        // Async reset mid-run
        do_clear();
        COUNT_MODE = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        check("mid_en", 32'(ENABLE), 32'd1);
        #2 RESET_N = 1'b0;
        #1;
        check("arst_en", 32'(ENABLE), 32'd0);
        check("arst_state", 32'(STATE), 32'd0);
        check("arst_cycles", CYCLES, 32'd0);
        check("arst_done", 32'(DONE), 32'd0);
        #3 RESET_N = 1'b1;
        tick(); tick();
        check("arst_idle", 32'(STATE), 32'd0);
        check("arst_no_done", 32'(DONE), 32'd0);

        // Clear from HALTED with CYCLES=7
        COUNT_MODE = 1'b1; RUN_COUNT = 16'd7; START = 1'b1;
        tick();
        START = 1'b0;
        guard = 0;
        while (STATE != 2'b11 && guard < 50) begin
            tick();
            guard++;
        end
        check("c7_cycles", CYCLES, 32'd7);
        do_clear();
        check("c7_clr_state", 32'(STATE), 32'd0);
        check("c7_clr_cycles", CYCLES, 32'd0);
        check("c7_clr_done", 32'(DONE), 32'd0);

        // Saturation on 4-bit counter
        COUNT_MODE = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("sat_en", 32'(enable_s), 32'd1);
        check("sat_cycles", 32'(cycles_s), 32'd15);
        HALT_REQ = 1'b1;
        tick();
        HALT_REQ = 1'b0;
        check("sat_hold", 32'(cycles_s), 32'd15);
        check("sat_wide", CYCLES, 32'd21);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
